// File: rtl/ram_dual_port.sv
// Simple dual-port RAM: one write port, one read port with a registered read pipeline,
// write-first collision bypass, per-word written flags and saturating access counters.
module ram_dual_port #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  rd_uninit,
  output logic                  collision,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written_q;

  logic [IdxW-1:0] wr_idx, rd_idx;
  logic            wr_in_range, rd_in_range;
  logic            wr_ok, rd_coll, rd_uninit_now;

  assign wr_idx      = wr_address[IdxW-1:0];
  assign rd_idx      = rd_address[IdxW-1:0];
  assign wr_in_range = {1'b0, wr_address} < DepthLim;
  assign rd_in_range = {1'b0, rd_address} < DepthLim;
  assign wr_ok       = write & wr_in_range;

  // Collision needs an accepted write; a dropped out-of-range write never bypasses.
  assign rd_coll       = read & wr_ok & (wr_address == rd_address);
  assign rd_uninit_now = ~rd_coll & (~rd_in_range | ~written_q[rd_idx]);

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      written_q <= '0;
    end else if (wr_ok) begin
      written_q[wr_idx] <= 1'b1;
    end
  end

  // Capture stage: resolution flags plus the address; the array itself is read one edge
  // later, which still sees only writes up to the capture edge.
  logic                  s0_valid_q, s0_coll_q, s0_uninit_q;
  logic [IdxW-1:0]       s0_idx_q;
  logic [DATA_WIDTH-1:0] s0_byp_q;
  logic [DATA_WIDTH-1:0] s0_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s0_valid_q  <= 1'b0;
      s0_coll_q   <= 1'b0;
      s0_uninit_q <= 1'b0;
      s0_idx_q    <= '0;
      s0_byp_q    <= '0;
    end else begin
      s0_valid_q  <= read;
      s0_coll_q   <= rd_coll;
      s0_uninit_q <= rd_uninit_now;
      if (read) begin
        s0_idx_q <= rd_idx;
      end
      if (rd_coll) begin
        s0_byp_q <= data_in;
      end
    end
  end

  always_comb begin
    s0_word = mem[s0_idx_q];
    if (s0_coll_q) begin
      s0_word = s0_byp_q;
    end else if (s0_uninit_q) begin
      s0_word = '0;
    end
  end

  logic                  fin_valid, fin_coll, fin_uninit;
  logic [DATA_WIDTH-1:0] fin_data;

  if (RD_LATENCY == 2) begin : gen_lat2
    logic                  s1_valid_q, s1_coll_q, s1_uninit_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s1_valid_q  <= 1'b0;
        s1_coll_q   <= 1'b0;
        s1_uninit_q <= 1'b0;
        s1_data_q   <= '0;
      end else begin
        s1_valid_q  <= s0_valid_q;
        s1_coll_q   <= s0_coll_q;
        s1_uninit_q <= s0_uninit_q;
        if (s0_valid_q) begin
          s1_data_q <= s0_word;
        end
      end
    end

    assign fin_valid  = s1_valid_q;
    assign fin_coll   = s1_coll_q;
    assign fin_uninit = s1_uninit_q;
    assign fin_data   = s1_data_q;
  end else begin : gen_lat1
    assign fin_valid  = s0_valid_q;
    assign fin_coll   = s0_coll_q;
    assign fin_uninit = s0_uninit_q;
    assign fin_data   = s0_word;
  end

  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q, rd_uninit_q, collision_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_uninit_q <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      rd_valid_q  <= fin_valid;
      rd_uninit_q <= fin_valid & fin_uninit;
      collision_q <= fin_valid & fin_coll;
      if (fin_valid) begin
        data_out_q <= fin_data;
      end
    end
  end

  logic [CNT_WIDTH-1:0] wr_count_q, rd_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      if (wr_ok && wr_count_q != '1) begin
        wr_count_q <= wr_count_q + CNT_WIDTH'(1);
      end
      if (read && rd_count_q != '1) begin
        rd_count_q <= rd_count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign rd_uninit = rd_uninit_q;
  assign collision = collision_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

  a_write_known: assert property (@(posedge clock) disable iff (reset) !$isunknown(write));
  a_read_known:  assert property (@(posedge clock) disable iff (reset) !$isunknown(read));

endmodule

// File: tb/tb_ram_dual_port.sv
// Scoreboard bench: two RAM configurations share one random/directed stimulus stream and are
// checked against an associative-array reference model.
module tb_ram_dual_port;

  localparam int DepthA = 4096, LatA = 1, MaxA = 65535;
  localparam int DepthB = 1024, LatB = 2, MaxB = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] data_in = '0;
  logic [11:0] wr_address = '0, rd_address = '0;
  logic        write = 1'b0, read = 1'b0;

  logic [63:0] a_data_out, b_data_out;
  logic        a_rd_valid, a_rd_uninit, a_collision;
  logic        b_rd_valid, b_rd_uninit, b_collision;
  logic [15:0] a_wr_count, a_rd_count;
  logic [3:0]  b_wr_count, b_rd_count;

  ram_dual_port dut_a (
    .clock(clock), .reset(reset), .data_in(data_in), .wr_address(wr_address), .write(write),
    .rd_address(rd_address), .read(read), .data_out(a_data_out), .rd_valid(a_rd_valid),
    .rd_uninit(a_rd_uninit), .collision(a_collision), .wr_count(a_wr_count),
    .rd_count(a_rd_count)
  );

  ram_dual_port #(
    .DATA_WIDTH(64), .ADDR_WIDTH(12), .DEPTH(DepthB), .RD_LATENCY(LatB), .CNT_WIDTH(4)
  ) dut_b (
    .clock(clock), .reset(reset), .data_in(data_in), .wr_address(wr_address), .write(write),
    .rd_address(rd_address), .read(read), .data_out(b_data_out), .rd_valid(b_rd_valid),
    .rd_uninit(b_rd_uninit), .collision(b_collision), .wr_count(b_wr_count),
    .rd_count(b_rd_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  typedef struct {
    logic [63:0] data;
    logic        uninit;
    logic        coll;
    int          due;
  } exp_t;

  exp_t        q_a[$], q_b[$];
  logic [63:0] mem_a [int], mem_b [int];
  int          wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  logic [63:0] last_a = '0, last_b = '0;

  // Reference behaviour of one posedge: reads resolve against the state before this edge.
  task automatic model_edge(input logic w, input int wa, input logic [63:0] din,
                            input logic r, input int ra);
    exp_t e;
    if (r) begin
      e.coll   = w && wa < DepthA && wa == ra;
      e.uninit = !e.coll && !(ra < DepthA && mem_a.exists(ra));
      e.data   = e.coll ? din : (e.uninit ? 64'd0 : mem_a[ra]);
      e.due    = cyc + 1 + LatA;
      q_a.push_back(e);
      if (rd_a < MaxA) rd_a++;
      e.coll   = w && wa < DepthB && wa == ra;
      e.uninit = !e.coll && !(ra < DepthB && mem_b.exists(ra));
      e.data   = e.coll ? din : (e.uninit ? 64'd0 : mem_b[ra]);
      e.due    = cyc + 1 + LatB;
      q_b.push_back(e);
      if (rd_b < MaxB) rd_b++;
    end
    if (w && wa < DepthA) begin
      mem_a[wa] = din;
      if (wr_a < MaxA) wr_a++;
    end
    if (w && wa < DepthB) begin
      mem_b[wa] = din;
      if (wr_b < MaxB) wr_b++;
    end
  endtask

  task automatic check_port(input int p, input logic v, input logic [63:0] d, input logic u,
                            input logic c, input int wc, input int rc);
    exp_t  e;
    string n;
    int    qs;
    n  = (p == 0) ? "a" : "b";
    qs = (p == 0) ? q_a.size() : q_b.size();
    checks++;
    if (v === 1'b1) begin
      if (qs == 0) begin
        errors++;
        $display("FAIL %s_spurious_valid cyc=%0d: got rd_valid=1 data=%h, required no result",
                 n, cyc, d);
      end else begin
        if (p == 0) e = q_a.pop_front();
        else        e = q_b.pop_front();
        if (d !== e.data || u !== e.uninit || c !== e.coll || cyc != e.due) begin
          errors++;
          $display("FAIL %s_read cyc=%0d: got data=%h uninit=%b coll=%b, required data=%h uninit=%b coll=%b at cyc=%0d",
                   n, cyc, d, u, c, e.data, e.uninit, e.coll, e.due);
        end
        if (p == 0) last_a = e.data;
        else        last_b = e.data;
      end
    end else begin
      if (qs != 0) begin
        if (p == 0) e = q_a[0];
        else        e = q_b[0];
      end
      if (v !== 1'b0 || u !== 1'b0 || c !== 1'b0 || d !== ((p == 0) ? last_a : last_b)) begin
        errors++;
        $display("FAIL %s_idle cyc=%0d: got valid=%b uninit=%b coll=%b data=%h, required 0/0/0 data=%h",
                 n, cyc, v, u, c, d, (p == 0) ? last_a : last_b);
      end else if (qs != 0 && e.due <= cyc) begin
        errors++;
        $display("FAIL %s_missing_valid cyc=%0d: got rd_valid=0, required data=%h due cyc=%0d",
                 n, cyc, e.data, e.due);
        if (p == 0) void'(q_a.pop_front());
        else        void'(q_b.pop_front());
      end
    end
    checks++;
    if (wc != ((p == 0) ? wr_a : wr_b) || rc != ((p == 0) ? rd_a : rd_b)) begin
      errors++;
      $display("FAIL %s_counters cyc=%0d: got wr=%0d rd=%0d, required wr=%0d rd=%0d",
               n, cyc, wc, rc, (p == 0) ? wr_a : wr_b, (p == 0) ? rd_a : rd_b);
    end
  endtask

  always @(negedge clock) begin
    check_port(0, a_rd_valid, a_data_out, a_rd_uninit, a_collision,
               int'(a_wr_count), int'(a_rd_count));
    check_port(1, b_rd_valid, b_data_out, b_rd_uninit, b_collision,
               int'(b_wr_count), int'(b_rd_count));
  end

  task automatic clear_model();
    q_a.delete(); q_b.delete(); mem_a.delete(); mem_b.delete();
    wr_a = 0; rd_a = 0; wr_b = 0; rd_b = 0;
    last_a = '0; last_b = '0;
  endtask

  // Called #1 after a posedge; any read still in flight is discarded by the reset.
  task automatic apply_reset();
    reset = 1'b1;
    clear_model();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic step(input logic w, input int wa, input logic [63:0] din,
                      input logic r, input int ra);
    write = w; wr_address = 12'(wa); data_in = din; read = r; rd_address = 12'(ra);
    @(posedge clock);
    model_edge(w, wa, din, r, ra);
    #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 64'd0, 1'b0, 0);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 15));
      1:       return int'($urandom_range(32'h3F8, 32'h407));
      default: return int'($urandom_range(32'hFF8, 32'hFFF));
    endcase
  endfunction

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    step(1'b0, 0, 64'd0, 1'b1, 'h005);
    idle(3);
    step(1'b1, 'h010, 64'hDEAD_BEEF_0000_0001, 1'b0, 0);
    step(1'b0, 0, 64'd0, 1'b1, 'h010);
    step(1'b1, 'hFFF, 64'h5555, 1'b0, 0);
    step(1'b1, 'hFFF, 64'h1234, 1'b1, 'hFFF);
    idle(3);
    for (int i = 0; i < 8; i++) step(1'b1, i, 64'(i * 3), 1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 0, 64'd0, 1'b1, i);
    idle(3);
    // A write one cycle after a read must not reach that read's result.
    step(1'b0, 0, 64'd0, 1'b1, 3);
    step(1'b1, 3, 64'hAAAA, 1'b0, 0);
    step(1'b0, 0, 64'd0, 1'b1, 3);
    step(1'b1, 'h7FF, 64'h77, 1'b0, 0);
    step(1'b0, 0, 64'd0, 1'b1, 'h7FF);
    for (int i = 0; i < 20; i++) step(1'b1, 'h100 + i, 64'(i), 1'b0, 0);
    idle(3);

    step(1'b1, 'h020, 64'h2020, 1'b0, 0);
    step(1'b0, 0, 64'd0, 1'b1, 'h020);
    apply_reset();
    step(1'b0, 0, 64'd0, 1'b1, 'h020);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      int          wa, ra;
      logic [63:0] din;
      wa  = pick();
      ra  = ($urandom_range(0, 3) == 0) ? wa : pick();
      din = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), wa, din, 1'($urandom_range(0, 1)), ra);
      if (i == 200) apply_reset();
    end
    idle(4);

    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d results outstanding, required 0/0", q_a.size(), q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
